// File: rtl/regfile_pkg.sv
// Shared types and sizes for the 8x16 register file and its read-select muxes.
package regfile_pkg;

  localparam int unsigned REG_DATA_W = 16;
  localparam int unsigned REG_DEPTH  = 8;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned WR_COUNT_W = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [WR_COUNT_W-1:0] wr_count_t;

  localparam wr_count_t WR_COUNT_MAX = '1;

  // Saturating increment for the debug write counter.
  function automatic wr_count_t wr_count_inc(input wr_count_t c);
    return (c == WR_COUNT_MAX) ? c : c + WR_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/reg_file_8x16_if.sv
// Write/read bus between the controller (master) and the register file (slave).
interface reg_file_8x16_if;
  import regfile_pkg::*;

  logic      W_en;
  reg_addr_t W_addr;
  reg_data_t W_data;
  reg_addr_t Ra_addr;
  reg_addr_t Rb_addr;
  reg_data_t Ra_data;
  reg_data_t Rb_data;
  wr_count_t Wr_count;

  modport master (
    output W_en, W_addr, W_data, Ra_addr, Rb_addr,
    input  Ra_data, Rb_data, Wr_count
  );

  modport slave (
    input  W_en, W_addr, W_data, Ra_addr, Rb_addr,
    output Ra_data, Rb_data, Wr_count
  );

endinterface

// File: rtl/Mux_16w_8_to_1.sv
// 16-bit 8-to-1 combinational select used by each register-file read port.
module Mux_16w_8_to_1
  import regfile_pkg::*;
(
  input  reg_data_t din [REG_DEPTH],
  input  reg_addr_t sel,
  output reg_data_t dout_c
);

  // Pick the selected entry.
  always_comb begin
    dout_c = '0;
    case (sel)
      3'd0:    dout_c = din[0];
      3'd1:    dout_c = din[1];
      3'd2:    dout_c = din[2];
      3'd3:    dout_c = din[3];
      3'd4:    dout_c = din[4];
      3'd5:    dout_c = din[5];
      3'd6:    dout_c = din[6];
      3'd7:    dout_c = din[7];
      default: dout_c = '0;
    endcase
  end

endmodule

// File: rtl/reg_file_8x16.sv
// Eight-entry 16-bit register file: one synchronous write port, two registered
// read ports, saturating write counter. Synchronous active-high Reset.
// Optional macro REGFILE_BYPASS_EN forwards same-edge write data to a read port
// whose address matches the write address; undefined gives read-before-write.
module reg_file_8x16
  import regfile_pkg::*;
(
  input logic             Clk,
  input logic             Reset,
  reg_file_8x16_if.slave  bus
);

  reg_data_t              regs [REG_DEPTH];
  logic [REG_DEPTH-1:0]   wr_sel_c;
  reg_data_t              mux_a_c;
  reg_data_t              mux_b_c;
  reg_data_t              ra_next_c;
  reg_data_t              rb_next_c;
  reg_data_t              ra_q;
  reg_data_t              rb_q;
  wr_count_t              wr_count_q;

  // One-hot write decode.
  always_comb begin
    wr_sel_c = '0;
    if (bus.W_en) wr_sel_c[bus.W_addr] = 1'b1;
  end

  // Storage array; reset clears every entry and drops any same-cycle write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) begin
        if (wr_sel_c[i]) regs[i] <= bus.W_data;
      end
    end
  end

  Mux_16w_8_to_1 u_mux_a (
    .din    (regs),
    .sel    (bus.Ra_addr),
    .dout_c (mux_a_c)
  );

  Mux_16w_8_to_1 u_mux_b (
    .din    (regs),
    .sel    (bus.Rb_addr),
    .dout_c (mux_b_c)
  );

  // Next read data: array value, optionally overridden by the in-flight write.
  always_comb begin
    ra_next_c = mux_a_c;
    rb_next_c = mux_b_c;
`ifdef REGFILE_BYPASS_EN
    if (bus.W_en && (bus.W_addr == bus.Ra_addr)) ra_next_c = bus.W_data;
    if (bus.W_en && (bus.W_addr == bus.Rb_addr)) rb_next_c = bus.W_data;
`endif
  end

  // Read-port output registers; update every cycle outside reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ra_q <= '0;
      rb_q <= '0;
    end else begin
      ra_q <= ra_next_c;
      rb_q <= rb_next_c;
    end
  end

  // Saturating count of accepted writes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_count_q <= '0;
    end else if (bus.W_en) begin
      wr_count_q <= wr_count_inc(wr_count_q);
    end
  end

  assign bus.Ra_data  = ra_q;
  assign bus.Rb_data  = rb_q;
  assign bus.Wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_8x16.sv
// Self-checking bench for reg_file_8x16: directed test-plan steps plus random
// traffic against an array-based reference model.
module tb_reg_file_8x16;

  logic Clk;
  logic Reset;

  reg_file_8x16_if bus_if ();

  reg_file_8x16 dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model state
  logic [15:0] mem [8];
  int          wcount;
  logic [15:0] exp_a;
  logic [15:0] exp_b;
  int          n_cmp;
  int          n_err;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then check all outputs.
  task automatic cyc(input string tag, input logic rst, input logic we,
                     input logic [2:0] wa, input logic [15:0] wd,
                     input logic [2:0] ra, input logic [2:0] rb);
    logic byp;
    Reset          = rst;
    bus_if.W_en    = we;
    bus_if.W_addr  = wa;
    bus_if.W_data  = wd;
    bus_if.Ra_addr = ra;
    bus_if.Rb_addr = rb;
`ifdef REGFILE_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    if (rst) begin
      exp_a  = 16'h0000;
      exp_b  = 16'h0000;
      wcount = 0;
      for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    end else begin
      exp_a = (byp && we && (wa == ra)) ? wd : mem[ra];
      exp_b = (byp && we && (wa == rb)) ? wd : mem[rb];
      if (we) begin
        mem[wa] = wd;
        wcount  = (wcount < 255) ? wcount + 1 : 255;
      end
    end
    @(posedge Clk);
    #1;
    chk16({tag, ".ra"}, bus_if.Ra_data, exp_a);
    chk16({tag, ".rb"}, bus_if.Rb_data, exp_b);
    chk8({tag, ".cnt"}, bus_if.Wr_count, 8'(wcount));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    wcount = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;

    // Reset for two cycles, then read every address on both ports
    cyc("rst0", 1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    cyc("rst1", 1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++)
      cyc("rd_after_rst", 1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i));
    chk16("rst_ra_zero", bus_if.Ra_data, 16'h0000);
    chk8("rst_cnt_zero", bus_if.Wr_count, 8'h00);

    // Fill reg[i] = A000+i, then read 3 and 6
    for (int i = 0; i < 8; i++)
      cyc("fill", 1'b0, 1'b1, 3'(i), 16'hA000 + 16'(i), 3'd0, 3'd1);
    cyc("rd36", 1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd6);
    chk16("plan_ra3", bus_if.Ra_data, 16'hA003);
    chk16("plan_rb6", bus_if.Rb_data, 16'hA006);
    chk8("plan_cnt8", bus_if.Wr_count, 8'd8);

    // Same-cycle write and read of reg[2]
    cyc("wr_rd_same", 1'b0, 1'b1, 3'd2, 16'h1234, 3'd2, 3'd2);
`ifdef REGFILE_BYPASS_EN
    chk16("same_cycle_bypass", bus_if.Ra_data, 16'h1234);
`else
    chk16("same_cycle_old", bus_if.Ra_data, 16'hA002);
`endif
    cyc("wr_rd_next", 1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd5);
    chk16("same_cycle_next", bus_if.Ra_data, 16'h1234);

    // Reset overrides a concurrent write
    cyc("rst_wr", 1'b1, 1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5);
    cyc("rd5_post_rst", 1'b0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd5);
    chk16("rst_drops_write", bus_if.Ra_data, 16'h0000);
    chk8("rst_drops_cnt", bus_if.Wr_count, 8'h00);

    // Both ports on the same address
    cyc("wr7", 1'b0, 1'b1, 3'd7, 16'hFFFF, 3'd0, 3'd0);
    cyc("rd77", 1'b0, 1'b0, 3'd0, 16'h0, 3'd7, 3'd7);
    chk16("same_addr_a", bus_if.Ra_data, 16'hFFFF);
    chk16("same_addr_b", bus_if.Rb_data, 16'hFFFF);

    // Random traffic with occasional reset
    for (int n = 0; n < 200; n++)
      cyc("rand", ($urandom_range(39) == 0), 1'($urandom),
          3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));

    // Saturation: reset, then 300 consecutive writes
    cyc("sat_rst", 1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    for (int n = 0; n < 300; n++)
      cyc("sat_wr", 1'b0, 1'b1, 3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
    chk8("sat_cnt_ff", bus_if.Wr_count, 8'hFF);
    for (int i = 0; i < 8; i++)
      cyc("sat_rd", 1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(i ^ 3));
    chk8("sat_cnt_hold", bus_if.Wr_count, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
